// File: rtl/led_flash_detector_if.sv
// Signal bundle between an LED line source and the flash detector.
// The detector takes the slave side; whatever drives the LED line and
// consumes the detection results takes the master side.
interface led_flash_detector_if;
    logic        LED_in;
    logic        flash_detected;
    logic        steady_on;
    logic        width_strobe;
    logic        width_is_high;
    logic [15:0] last_width;

    modport master (
        output LED_in,
        input  flash_detected,
        input  steady_on,
        input  width_strobe,
        input  width_is_high,
        input  last_width
    );

    modport slave (
        input  LED_in,
        output flash_detected,
        output steady_on,
        output width_strobe,
        output width_is_high,
        output last_width
    );
endinterface

// File: rtl/led_flash_detector.sv
// LED flash detector: synchronises a blinking LED line and measures every
// high and low phase in clock cycles. Enough consecutive phases inside the
// nominal timing windows confirm flashing. A high phase that runs past its
// window marks the LED as stuck on.
module led_flash_detector #(
    parameter int HIGH_PERIOD = 600,
    parameter int LOW_PERIOD  = 600,
    parameter int TOL         = 60,
    parameter int MIN_GOOD    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    led_flash_detector_if.slave   bus
);

    // Nominal phase widths and inclusive acceptance windows (MIN clamped at 0)
    localparam int          HNOM_I     = HIGH_PERIOD + 1;
    localparam int          LNOM_I     = LOW_PERIOD + 1;
    localparam int          HMIN_I     = (HNOM_I > TOL) ? (HNOM_I - TOL) : 0;
    localparam int          LMIN_I     = (LNOM_I > TOL) ? (LNOM_I - TOL) : 0;
    localparam logic [15:0] HMIN_C     = 16'(HMIN_I);
    localparam logic [15:0] HMAX_C     = 16'(HNOM_I + TOL);
    localparam logic [15:0] LMIN_C     = 16'(LMIN_I);
    localparam logic [15:0] LMAX_C     = 16'(LNOM_I + TOL);
    localparam logic [3:0]  MIN_GOOD_C = 4'(MIN_GOOD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HIGH  = 2'd1,
        S_LOW   = 2'd2,
        S_STUCK = 2'd3
    } state_t;

    // Inclusive unsigned window test on a captured width
    function automatic logic in_window(input logic [15:0] width,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        in_window = (width >= lo) && (width <= hi);
    endfunction

    // Good-phase counter step, saturating at the detection threshold
    function automatic logic [3:0] sat_inc_good(input logic [3:0] good);
        if (good < MIN_GOOD_C) begin
            sat_inc_good = good + 4'd1;
        end else begin
            sat_inc_good = MIN_GOOD_C;
        end
    endfunction

    logic        s1_r;
    logic        s2_r;
    logic        s3_r;
    logic [15:0] cnt_r;
    logic [3:0]  good_r;
    state_t      state_r;
    logic        flash_r;
    logic        steady_r;
    logic        strobe_r;
    logic        is_high_r;
    logic [15:0] width_r;

    logic        edge_s;
    logic        rise_s;
    logic        fall_s;
    state_t      state_s;
    logic [3:0]  good_s;
    logic        flash_s;
    logic        steady_s;
    logic        strobe_s;
    logic        is_high_s;
    logic [15:0] width_s;

    // An edge is a disagreement between the last two synchronised samples
    assign edge_s = s2_r ^ s3_r;
    assign rise_s = edge_s & s2_r;
    assign fall_s = edge_s & ~s2_r;

    // Two-flop synchroniser for the asynchronous LED line plus edge-history flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= bus.LED_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Phase length counter: restarts at 1 on every edge, saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (edge_s) begin
            cnt_r <= 16'd1;
        end else if (cnt_r != 16'hFFFF) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // State and registered-output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            good_r    <= 4'd0;
            flash_r   <= 1'b0;
            steady_r  <= 1'b0;
            strobe_r  <= 1'b0;
            is_high_r <= 1'b0;
            width_r   <= 16'd0;
        end else begin
            state_r   <= state_s;
            good_r    <= good_s;
            flash_r   <= flash_s;
            steady_r  <= steady_s;
            strobe_r  <= strobe_s;
            is_high_r <= is_high_s;
            width_r   <= width_s;
        end
    end

    // Next-state logic: capture and evaluate phases, detect timeouts.
    // An edge coinciding with cnt==MAX takes the capture path, so a width
    // of exactly MAX is still accepted.
    always_comb begin
        state_s   = state_r;
        good_s    = good_r;
        flash_s   = flash_r;
        steady_s  = steady_r;
        strobe_s  = 1'b0;
        is_high_s = 1'b0;
        width_s   = width_r;
        case (state_r)
            S_IDLE: begin
                // Idle low length is unknown, so the first rising edge only starts measuring
                if (rise_s) begin
                    state_s = S_HIGH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HIGH: begin
                if (fall_s) begin
                    state_s   = S_LOW;
                    strobe_s  = 1'b1;
                    is_high_s = 1'b1;
                    width_s   = cnt_r;
                    if (in_window(cnt_r, HMIN_C, HMAX_C)) begin
                        good_s  = sat_inc_good(good_r);
                        flash_s = (good_s == MIN_GOOD_C);
                    end else begin
                        good_s  = 4'd0;
                        flash_s = 1'b0;
                    end
                end else if (cnt_r == HMAX_C) begin
                    state_s  = S_STUCK;
                    good_s   = 4'd0;
                    flash_s  = 1'b0;
                    steady_s = 1'b1;
                end else begin
                    state_s = S_HIGH;
                end
            end
            S_LOW: begin
                if (rise_s) begin
                    state_s   = S_HIGH;
                    strobe_s  = 1'b1;
                    is_high_s = 1'b0;
                    width_s   = cnt_r;
                    if (in_window(cnt_r, LMIN_C, LMAX_C)) begin
                        good_s  = sat_inc_good(good_r);
                        flash_s = (good_s == MIN_GOOD_C);
                    end else begin
                        good_s  = 4'd0;
                        flash_s = 1'b0;
                    end
                end else if (cnt_r == LMAX_C) begin
                    state_s = S_IDLE;
                    good_s  = 4'd0;
                    flash_s = 1'b0;
                end else begin
                    state_s = S_LOW;
                end
            end
            S_STUCK: begin
                // Report the (possibly saturated) stuck width, no evaluation: good count is already 0
                if (fall_s) begin
                    state_s   = S_LOW;
                    steady_s  = 1'b0;
                    strobe_s  = 1'b1;
                    is_high_s = 1'b1;
                    width_s   = cnt_r;
                end else begin
                    state_s = S_STUCK;
                end
            end
            default: begin
                state_s  = S_IDLE;
                good_s   = 4'd0;
                flash_s  = 1'b0;
                steady_s = 1'b0;
            end
        endcase
    end

    assign bus.flash_detected = flash_r;
    assign bus.steady_on      = steady_r;
    assign bus.width_strobe   = strobe_r;
    assign bus.width_is_high  = is_high_r;
    assign bus.last_width     = width_r;

endmodule

// File: tb/tb_led_flash_detector.sv
// Bench for led_flash_detector: drives the LED line as a sequence of
// (level, length) phases and predicts each width report from the phase
// list using the window rules directly.
module tb_led_flash_detector;

    localparam int HMAX = 600 + 1 + 60;
    localparam int HMIN = 600 + 1 - 60;
    localparam int LMAX = 600 + 1 + 60;
    localparam int LMIN = 600 + 1 - 60;
    localparam int NEED = 3;

    typedef struct {
        logic [15:0] w;
        logic        hi;
        logic        fl;
    } exp_t;

    logic clk;
    logic rst;
    led_flash_detector_if bus();

    led_flash_detector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t exp_q[$];

    // reference model state
    int   m_good       = 0;
    logic m_flash      = 1'b0;
    logic m_after_high = 1'b0;
    logic cur_lvl      = 1'b0;
    int   cur_len      = 0;
    logic prev_strobe  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_eval(input logic ok);
        if (ok) begin
            if (m_good < NEED) m_good++;
            m_flash = (m_good == NEED);
        end else begin
            m_good  = 0;
            m_flash = 1'b0;
        end
    endtask

    // A finished phase of level lvl lasting w cycles
    task automatic model_close(input logic lvl, input int w);
        exp_t e;
        if (lvl) begin
            if (w > HMAX) begin
                m_good  = 0;
                m_flash = 1'b0;
            end else begin
                model_eval(w >= HMIN);
            end
            e.w  = (w > 65535) ? 16'hFFFF : 16'(w);
            e.hi = 1'b1;
            e.fl = m_flash;
            exp_q.push_back(e);
            m_after_high = 1'b1;
        end else begin
            if (m_after_high) begin
                if (w > LMAX) begin
                    m_good  = 0;
                    m_flash = 1'b0;
                end else begin
                    model_eval(w >= LMIN);
                    e.w  = 16'(w);
                    e.hi = 1'b0;
                    e.fl = m_flash;
                    exp_q.push_back(e);
                end
            end
            m_after_high = 1'b0;
        end
    endtask

    // Hold LED_in at lvl for n clock cycles (changes on the falling clock edge)
    task automatic drive(input logic lvl, input int n);
        if (lvl != cur_lvl) begin
            model_close(cur_lvl, cur_len);
            cur_lvl = lvl;
            cur_len = 0;
        end
        bus.LED_in = lvl;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cur_len++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_flash"},  {31'd0, bus.flash_detected}, 32'd0);
        check_eq({tag, "_steady"}, {31'd0, bus.steady_on},      32'd0);
        check_eq({tag, "_strobe"}, {31'd0, bus.width_strobe},   32'd0);
        check_eq({tag, "_ishigh"}, {31'd0, bus.width_is_high},  32'd0);
        check_eq({tag, "_width"},  {16'd0, bus.last_width},     32'd0);
    endtask

    // Width-report monitor: every strobe must match the next predicted phase
    always @(negedge clk) begin
        if (!rst && bus.width_strobe) begin
            check_eq("strobe_gap", {31'd0, prev_strobe}, 32'd0);
            check_eq("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("last_width", {16'd0, bus.last_width},     {16'd0, e.w});
                check_eq("is_high",    {31'd0, bus.width_is_high},  {31'd0, e.hi});
                check_eq("flash_at_strobe", {31'd0, bus.flash_detected}, {31'd0, e.fl});
                check_eq("steady_at_strobe", {31'd0, bus.steady_on}, 32'd0);
            end
        end
        prev_strobe <= bus.width_strobe;
    end

    initial begin
        rst = 1'b1;
        bus.LED_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // nominal blink 601/601
        drive(1'b0, 20);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 601);
            drive(1'b0, 601);
        end
        check_eq("nominal_flash", {31'd0, bus.flash_detected}, 32'd1);

        // asynchronous reset in the middle of a high phase
        drive(1'b1, 300);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        bus.LED_in = 1'b0;
        cur_lvl = 1'b0;
        cur_len = 0;
        m_good = 0;
        m_flash = 1'b0;
        m_after_high = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 20);
        check_all_zero("after_release");

        // window edges: 541 and 661 accepted, 540 rejected, then re-detect
        drive(1'b1, 601);
        drive(1'b0, 601);
        drive(1'b1, 541);
        drive(1'b0, 601);
        drive(1'b1, 661);
        drive(1'b0, 601);
        drive(1'b1, 540);
        drive(1'b0, 601);
        drive(1'b1, 601);
        drive(1'b0, 601);
        drive(1'b1, 601);

        // flashing stops: flash falls on the LMAX-th synced-low cycle
        drive(1'b0, LMAX + 2);
        check_eq("stop_flash_before", {31'd0, bus.flash_detected}, 32'd1);
        drive(1'b0, 1);
        check_eq("stop_flash_after", {31'd0, bus.flash_detected}, 32'd0);
        drive(1'b0, 100);

        // re-detect from idle, then hold high 2000 cycles
        drive(1'b1, 601);
        drive(1'b0, 601);
        drive(1'b1, 601);
        drive(1'b0, 601);
        drive(1'b1, HMAX + 2);
        check_eq("stuck_steady_before", {31'd0, bus.steady_on},      32'd0);
        check_eq("stuck_flash_before",  {31'd0, bus.flash_detected}, 32'd1);
        drive(1'b1, 1);
        check_eq("stuck_steady_after",  {31'd0, bus.steady_on},      32'd1);
        check_eq("stuck_flash_after",   {31'd0, bus.flash_detected}, 32'd0);
        drive(1'b1, 2000 - HMAX - 3);
        drive(1'b0, 601);
        check_eq("stuck_released", {31'd0, bus.steady_on}, 32'd0);

        // randomised phase widths around the windows
        for (int k = 0; k < 6; k++) begin
            drive((k % 2 == 0) ? 1'b1 : 1'b0, int'($urandom_range(700, 530)));
        end

        // very long high phase saturates the counter
        drive(1'b1, 65600);
        drive(1'b0, 30);
        check_eq("sat_width", {16'd0, bus.last_width}, 32'd65535);

        repeat (10) @(negedge clk);
        check_eq("pending_reports", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/led_flash_detector.md
# led_flash_detector

Receive-side counterpart of the LED flasher. Samples a blinking LED line, measures each high and low phase in clock cycles, and asserts `flash_detected` once enough consecutive phases match the nominal blink timing. Also flags a stuck-on LED. Sits in the harness on LED/indicator inputs so that test logic can confirm a flash request was actually signalled.

## Interface
- `HIGH_PERIOD`, 600: nominal high phase is HIGH_PERIOD+1 cycles (400 ms at 1.5 kHz).
- `LOW_PERIOD`, 600: nominal low phase is LOW_PERIOD+1 cycles.
- `TOL`, 60: allowed ± deviation in cycles from the nominal phase width.
- `MIN_GOOD`, 3: number of consecutive in-window phases required to assert detection (1..15).
- Constraint: max(HIGH_PERIOD, LOW_PERIOD)+1+TOL < 65535.
- `clk` input 1: single clock for the whole block.
- `rst` input 1: reset, asynchronous, active-high.
- `LED_in` input 1: LED line being monitored. It may be asynchronous to `clk`.
- `flash_detected` output 1: periodic blinking is confirmed.
- `steady_on` output 1: the LED has been held high longer than the allowed high window.
- `width_strobe` output 1: one-cycle pulse when a phase width is captured.
- `width_is_high` output 1: the captured phase was high. Valid while `width_strobe` is asserted.
- `last_width` output 16: the captured phase length in cycles. Holds its value until the next strobe.

## Operation
- **Input synchronisation.** `LED_in` passes through 2 flops (s1, s2), then a third flop s3.
  - An edge is s2≠s3.
  - Rising edge: s2=1. Falling edge: s2=0.
- **Phase counter `cnt`.** 16 bits, saturating at 16'hFFFF.
  - On an edge cycle, `cnt` is loaded with 1.
  - Otherwise `cnt` increments by 1.
  - A level held for exactly W cycles is captured as W.
- **Windows.**
  - HMIN/HMAX = HIGH_PERIOD+1∓TOL.
  - LMIN/LMAX = LOW_PERIOD+1∓TOL.
  - Both bounds are inclusive. Compare unsigned; clamp the MIN bound at 0.
- **Evaluating a captured width.**
  - In-window: `good_cnt` increments, saturating at MIN_GOOD. `flash_detected` is set when `good_cnt` reaches MIN_GOOD.
  - Out-of-window: `good_cnt`←0 and `flash_detected`←0.
- **State machine.**
  - S_IDLE (after reset)
    - Rising edge → S_HIGH.
    - No capture and no strobe: the idle low length is unknown.
  - S_HIGH
    - Falling edge → S_LOW. Capture `cnt` as a high width, emit the strobe, evaluate.
    - If the level is still high and `cnt`==HMAX → S_STUCK. Set `good_cnt`←0, `flash_detected`←0, `steady_on`←1.
  - S_LOW
    - Rising edge → S_HIGH. Capture as a low width, emit the strobe, evaluate.
    - If the level is still low and `cnt`==LMAX → S_IDLE. Set `good_cnt`←0, `flash_detected`←0.
  - S_STUCK
    - Falling edge → S_LOW. Set `steady_on`←0.
    - Emit the strobe with the saturated/actual `cnt` and `width_is_high`=1.
    - Do not evaluate: `good_cnt` is already 0.
- **Simultaneous events.** An edge on the same cycle as `cnt`==HMAX or `cnt`==LMAX takes the edge path. The width then equals MAX and is in-window.
- **Reset values.**
  - `rst` asserted at any time, including mid-phase, forces S_IDLE.
  - s1, s2, s3, `cnt`, `good_cnt` are cleared.
  - All outputs read 0: `flash_detected`, `steady_on`, `width_strobe`, `width_is_high`, `last_width`.
  - After release, the first rising edge starts a fresh measurement.

## Timing
- All outputs are registered.
- A transition on `LED_in` first sampled at clock edge N:
  - s2 changes at N+1.
  - The edge is detected in the cycle after N+1.
  - `width_strobe`, `last_width`, `width_is_high` and the `flash_detected` update all appear after edge N+2.
- Detection latency with defaults: `flash_detected` rises with the strobe of the MIN_GOOD-th consecutive valid phase. The phases counted are high1, low1, high2, so it rises 2 cycles after the 2nd falling edge is sampled.
- Loss of flashing, low held: `flash_detected` falls 2 cycles after the input has been low LMAX (661) cycles, i.e. on the LMAX-th cycle of synced low.
- Stuck high: `steady_on` rises 2 cycles after the input has been high HMAX (661) cycles, i.e. on the HMAX-th cycle of synced high. `flash_detected` falls on the same edge.
- `width_strobe` is never high for 2 consecutive cycles.

## Test plan
- Reset: assert `rst` asynchronously mid-S_HIGH → all outputs 0 immediately. After release with `LED_in`=0, nothing changes.
- Nominal blink, 601 high / 601 low repeated:
  - Strobes report 601 with `width_is_high` alternating 1,0,1.
  - `flash_detected`=1 from the 3rd strobe onward.
- Window edges, high widths 541 and 661 → accepted (`good_cnt` advances). 540 → `flash_detected`←0 and `good_cnt`←0. Re-detect after 3 further valid phases.
- Flashing stops, input held low after a detected blink → `flash_detected` falls on the 661st synced-low cycle. State S_IDLE, no strobe.
- Input held high for 2000 cycles:
  - `steady_on`=1 from the 661st synced-high cycle.
  - On the falling edge: `steady_on`=0, strobe with `last_width`=2000, `flash_detected` stays 0.
- Input held high for 70000 cycles → `last_width`=65535 at the falling edge.
